// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART image controller: FSM state encoding and default widths.
package uart_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [2:0] {
    LOAD = 3'd0,
    IDLE = 3'd1,
    RD   = 3'd2,
    SEND = 3'd3,
    WAIT = 3'd4
  } state_e;

endpackage

// File: rtl/img_addr_cnt.sv
// Image byte counter: synchronous clear/increment, one cycle to update, flags the last byte.
// One bit wider than the address so a full 2^ADDR_W image never wraps before the flag.
module img_addr_cnt #(
  parameter int ADDR_W    = 16,
  parameter int IMG_BYTES = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              tc_o
);

  localparam int              CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(IMG_BYTES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign addr_o = cnt_q[ADDR_W-1:0];
  assign tc_o   = (cnt_q == LAST);

endmodule

// File: rtl/uart_image_ctrl.sv
// Loads an image from UART rx into RAM, lends RAM to the processor, then streams it back out.
// Byte out 2 cycles after its read starts; the next byte waits for tx_done (no rx backpressure).
module uart_image_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int IMG_BYTES = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_done,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic              proc_we,
  input  logic [DATA_W-1:0] proc_wdata,
  input  logic              start_tx,
  input  logic              reload,
  output logic              load_done,
  output logic              tx_fin,
  output logic              proc_grant,
  output logic [7:0]        rx_drop_cnt
);

  state_e            state_q, state_d;
  logic              cnt_clr, cnt_inc, cnt_tc;
  logic [ADDR_W-1:0] cnt_addr;

  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              load_done_q, load_done_d;
  logic              tx_fin_q, tx_fin_d;
  logic [7:0]        drop_q, drop_d;

  img_addr_cnt #(
    .ADDR_W    (ADDR_W),
    .IMG_BYTES (IMG_BYTES)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .addr_o (cnt_addr),
    .tc_o   (cnt_tc)
  );

  // RAM port mux: processor owns it in IDLE, otherwise the counter drives the address.
  always_comb begin
    ram_addr  = cnt_addr;
    ram_wdata = rx_data;
    ram_we    = 1'b0;
    if (state_q == IDLE) begin
      ram_addr  = proc_addr;
      ram_wdata = proc_wdata;
      ram_we    = proc_we;
    end else if (state_q == LOAD) begin
      ram_we = rx_valid && !reload;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (reload) begin
      state_d = LOAD;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          if (rx_valid) begin
            if (cnt_tc) begin
              cnt_clr = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        IDLE: begin
          if (start_tx) begin
            cnt_clr = 1'b1;
            state_d = RD;
          end
        end
        RD:   state_d = SEND;
        SEND: state_d = WAIT;
        WAIT: begin
          if (tx_done) begin
            if (cnt_tc) begin
              cnt_clr = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_inc = 1'b1;
              state_d = RD;
            end
          end
        end
        default: begin
          cnt_clr = 1'b1;
          state_d = LOAD;
        end
      endcase
    end
  end

  always_comb begin
    tx_valid_d  = !reload && (state_q == SEND);
    tx_data_d   = (state_q == SEND) ? ram_rdata : tx_data_q;
    tx_fin_d    = !reload && (state_q == WAIT) && tx_done && cnt_tc;
    load_done_d = load_done_q;
    drop_d      = drop_q;
    if (reload) begin
      load_done_d = 1'b0;
      drop_d      = 8'd0;
    end else begin
      if ((state_q == LOAD) && rx_valid && cnt_tc) load_done_d = 1'b1;
      if ((state_q != LOAD) && rx_valid && (drop_q != 8'd255)) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      load_done_q <= 1'b0;
      tx_fin_q    <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      load_done_q <= load_done_d;
      tx_fin_q    <= tx_fin_d;
      drop_q      <= drop_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign load_done   = load_done_q;
  assign tx_fin      = tx_fin_q;
  assign rx_drop_cnt = drop_q;
  assign proc_grant  = (state_q == IDLE);

endmodule

// File: tb/tb_uart_image_ctrl.sv
// Directed bench for uart_image_ctrl with a 4-byte image and a 1-cycle-latency RAM model.
module tb_uart_image_ctrl;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid, tx_done, tx_valid, ram_we, proc_we, start_tx, reload;
  logic [DW-1:0] rx_data, tx_data, ram_wdata, ram_rdata, proc_wdata;
  logic [AW-1:0] ram_addr, proc_addr;
  logic          load_done, tx_fin, proc_grant;
  logic [7:0]    rx_drop_cnt;

  logic [DW-1:0] mem [16];
  int            txv_cnt = 0;
  int            fin_cnt = 0;
  int            n_chk   = 0;
  int            n_err   = 0;
  logic [DW-1:0] img [NB] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  uart_image_ctrl #(.DATA_W(DW), .ADDR_W(AW), .IMG_BYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .tx_done(tx_done),
    .tx_valid(tx_valid), .tx_data(tx_data), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata), .proc_addr(proc_addr), .proc_we(proc_we),
    .proc_wdata(proc_wdata), .start_tx(start_tx), .reload(reload), .load_done(load_done),
    .tx_fin(tx_fin), .proc_grant(proc_grant), .rx_drop_cnt(rx_drop_cnt)
  );

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[3:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[3:0]];
  end

  always @(negedge clk) begin
    if (tx_valid) txv_cnt <= txv_cnt + 1;
    if (tx_fin)   fin_cnt <= fin_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [DW-1:0] b, input logic [AW-1:0] exp_addr);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    chk("ld_we", ram_we, 1);
    chk("ld_addr", ram_addr, exp_addr);
    chk("ld_wdata", ram_wdata, b);
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic load_image();
    for (int i = 0; i < NB; i++) begin
      if (i == NB - 1) chk("ld_notdone", load_done, 0);
      send_rx(img[i], AW'(i));
    end
    chk("ld_done", load_done, 1);
    chk("ld_idle", proc_grant, 1);
  endtask

  task automatic wait_txv(output logic [DW-1:0] d);
    bit found = 0;
    d = '0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (tx_valid) begin
        found = 1;
        d = tx_data;
      end
    end
    chk("txv_timeout", found, 1);
  endtask

  task automatic pulse_done_after5();
    repeat (5) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  logic [DW-1:0] got;
  int            base;

  initial begin
    rst_n = 1'b0; rx_valid = 0; rx_data = 0; tx_done = 0; proc_addr = 0;
    proc_we = 0; proc_wdata = 0; start_tx = 0; reload = 0;
    repeat (3) tick();
    chk("rst_txv", tx_valid, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_ldone", load_done, 0);
    chk("rst_fin", tx_fin, 0);
    chk("rst_grant", proc_grant, 0);
    chk("rst_drop", rx_drop_cnt, 0);
    chk("rst_txdata", tx_data, 0);
    rst_n = 1'b1;
    tick();

    load_image();
    for (int i = 0; i < NB; i++) chk("ram_img", mem[i], img[i]);

    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    chk("tx_grant_off", proc_grant, 0);
    for (int i = 0; i < NB; i++) begin
      wait_txv(got);
      chk("tx_byte", got, img[i]);
      tick();
      chk("tx_strobe1", tx_valid, 0);
      repeat (4) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (i < NB - 1) chk("tx_nofin", tx_fin, 0);
    end
    chk("tx_fin", tx_fin, 1);
    chk("tx_idle", proc_grant, 1);
    tick();
    chk("tx_fin_pulse", tx_fin, 0);
    chk("tx_count", txv_cnt, NB);
    chk("fin_count", fin_cnt, 1);

    proc_we = 1'b1; proc_addr = 16'd2; proc_wdata = 8'hA5;
    #1;
    chk("proc_we", ram_we, 1);
    chk("proc_addr", ram_addr, 2);
    chk("proc_wdata", ram_wdata, 8'hA5);
    tick();
    proc_we = 1'b0;
    tick();
    chk("proc_ram", mem[2], 8'hA5);

    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    wait_txv(got);
    chk("wait_byte0", got, 8'h11);
    proc_addr = 16'd5; proc_wdata = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = 8'hEE; proc_we = 1'b1;
      #1;
      chk("drop_no_we", ram_we, 0);
      tick();
    end
    rx_valid = 1'b0; proc_we = 1'b0;
    chk("drop_cnt3", rx_drop_cnt, 3);
    tick();
    chk("ram5_clean", mem[5], 0);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk("rl_drop_clr", rx_drop_cnt, 0);
    chk("rl_ldone", load_done, 0);
    chk("rl_grant", proc_grant, 0);
    load_image();

    base = txv_cnt;
    reload = 1'b1; start_tx = 1'b1;
    tick();
    reload = 1'b0; start_tx = 1'b0;
    chk("both_ldone", load_done, 0);
    chk("both_grant", proc_grant, 0);
    repeat (6) tick();
    chk("both_no_txv", txv_cnt, base);
    chk("both_load", proc_grant, 0);
    load_image();

    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    wait_txv(got);
    chk("rst_tx_b0", got, 8'h11);
    pulse_done_after5();
    wait_txv(got);
    chk("rst_tx_b1", got, 8'h22);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_txv", tx_valid, 0);
    chk("arst_we", ram_we, 0);
    base = txv_cnt;
    repeat (3) tick();
    chk("arst_txdata", tx_data, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_no_txv", txv_cnt, base);
    chk("post_grant", proc_grant, 0);
    chk("post_ldone", load_done, 0);
    send_rx(8'h77, 16'd0);
    chk("fin_total", fin_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
